if_id_queue: RTL and testbench

Parametrised IF/ID pipeline buffer that replaces the single-entry IF/ID register with a DEPTH-entry FIFO. It sits between the instruction fetch stage and the decode stage. It decouples fetch from decode back-pressure through a valid/ready handshake on both sides, and it kills all queued instructions on a flush or branch misprediction. When the queue is empty it presents an all-zero bubble (pc = 0, inst = 0) to decode.

---
 rtl/if_id_queue_if.sv | 38 +++
 rtl/if_id_queue.sv | 80 ++++++++
 tb/tb_if_id_queue.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/if_id_queue_if.sv
// if_id_queue_if
//   Handshake bundle between fetch, the IF/ID queue and decode.
//   master : fetch/decode side (drives kills, fetch data and decode ready)
//   slave  : queue side (drives ready, head entry and occupancy)
//   Signals:
//     flush, i_nt_pt, i_t_pnt : kill sources (any one empties the queue)
//     i_valid, i_pc, i_inst   : fetched instruction offered to the queue
//     o_ready                 : queue can accept an instruction
//     o_valid, o_pc, o_inst   : head entry presented to decode (zero when empty)
//     i_ready                 : decode consumes the head this cycle
//     o_count                 : current occupancy
interface if_id_queue_if #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 2
);
  logic              flush;
  logic              i_nt_pt;
  logic              i_t_pnt;
  logic              i_valid;
  logic [DATA_W-1:0] i_pc;
  logic [DATA_W-1:0] i_inst;
  logic              i_ready;
  logic              o_ready;
  logic              o_valid;
  logic [DATA_W-1:0] o_pc;
  logic [DATA_W-1:0] o_inst;
  logic [CNT_W-1:0]  o_count;

  modport master (
    output flush, i_nt_pt, i_t_pnt, i_valid, i_pc, i_inst, i_ready,
    input  o_ready, o_valid, o_pc, o_inst, o_count
  );

  modport slave (
    input  flush, i_nt_pt, i_t_pnt, i_valid, i_pc, i_inst, i_ready,
    output o_ready, o_valid, o_pc, o_inst, o_count
  );
endinterface

// File: rtl/if_id_queue.sv
// if_id_queue
//   DEPTH-entry FIFO standing in for the IF/ID pipeline register. Fetch
//   pushes {pc, inst} under a valid/ready handshake, decode pops the head.
//   Any kill (flush or either branch mispredict) empties the queue at the
//   next edge. When empty, an all-zero bubble is presented to decode.
//   Ports:
//     clk : clock, all state changes on the rising edge
//     rst : asynchronous active-high reset
//     q   : if_id_queue_if.slave handshake bundle
module if_id_queue #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 2,
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  if_id_queue_if.slave  q
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [2*DATA_W-1:0] mem_reg [DEPTH];
  logic [PTR_W-1:0]    wp_reg;
  logic [PTR_W-1:0]    rp_reg;
  logic [CNT_W-1:0]    count_reg;
  logic [CNT_W-1:0]    count_next;

  logic                kill;
  logic                push;
  logic                pop;
  logic                full;
  logic                empty;
  logic [2*DATA_W-1:0] head;

  assign kill  = q.flush | q.i_nt_pt | q.i_t_pnt;
  // Ready/valid come from the registered count only, so a full queue refuses
  // a push even when decode pops in the same cycle.
  assign full  = (count_reg == CNT_W'(DEPTH));
  assign empty = (count_reg == '0);
  assign push  = q.i_valid & ~full & ~kill;
  assign pop   = ~empty & q.i_ready & ~kill;

  always_comb begin
    count_next = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + CNT_W'(1);
      2'b01:   count_next = count_reg - CNT_W'(1);
      default: count_next = count_reg;
    endcase
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp_reg    <= '0;
      rp_reg    <= '0;
      count_reg <= '0;
    end else if (kill) begin
      wp_reg    <= '0;
      rp_reg    <= '0;
      count_reg <= '0;
    end else begin
      if (push) wp_reg <= wp_reg + PTR_W'(1);
      if (pop)  rp_reg <= rp_reg + PTR_W'(1);
      count_reg <= count_next;
    end
  end

  // Storage is never reset; stale entries are hidden by the count.
  always_ff @(posedge clk) begin
    if (push) mem_reg[wp_reg] <= {q.i_pc, q.i_inst};
  end

  assign head = mem_reg[rp_reg];

  assign q.o_ready = ~full;
  assign q.o_valid = ~empty;
  assign q.o_pc    = empty ? '0 : head[2*DATA_W-1:DATA_W];
  assign q.o_inst  = empty ? '0 : head[DATA_W-1:0];
  assign q.o_count = count_reg;
endmodule

// File: tb/tb_if_id_queue.sv
// tb_if_id_queue
//   Drives identical stimulus into a DEPTH=2 and a DEPTH=4 queue and checks
//   both against a shift-array FIFO model after every cycle.
module tb_if_id_queue;
  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  if_id_queue_if #(.DATA_W(32), .CNT_W(2)) bus2 ();
  if_id_queue_if #(.DATA_W(32), .CNT_W(3)) bus4 ();

  if_id_queue #(.DATA_W(32), .DEPTH(2)) dut2 (.clk(clk), .rst(rst), .q(bus2.slave));
  if_id_queue #(.DATA_W(32), .DEPTH(4)) dut4 (.clk(clk), .rst(rst), .q(bus4.slave));

  int total = 0;
  int bad   = 0;

  int          depth_of [2] = '{2, 4};
  logic [63:0] mdat [2][8];
  int          mcnt [2];

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(string tag);
    logic        ev, er, ov, orr;
    logic [63:0] eh;
    logic [31:0] opc, oinst;
    int          ocnt;
    for (int k = 0; k < 2; k++) begin
      ev = (mcnt[k] != 0);
      er = (mcnt[k] < depth_of[k]);
      eh = ev ? mdat[k][0] : 64'd0;
      if (k == 0) begin
        ov = bus2.o_valid; orr = bus2.o_ready; opc = bus2.o_pc;
        oinst = bus2.o_inst; ocnt = int'(bus2.o_count);
      end else begin
        ov = bus4.o_valid; orr = bus4.o_ready; opc = bus4.o_pc;
        oinst = bus4.o_inst; ocnt = int'(bus4.o_count);
      end
      chk($sformatf("%s.d%0d.valid", tag, depth_of[k]), 64'(ov), 64'(ev));
      chk($sformatf("%s.d%0d.ready", tag, depth_of[k]), 64'(orr), 64'(er));
      chk($sformatf("%s.d%0d.pc", tag, depth_of[k]), 64'(opc), 64'(eh[63:32]));
      chk($sformatf("%s.d%0d.inst", tag, depth_of[k]), 64'(oinst), 64'(eh[31:0]));
      chk($sformatf("%s.d%0d.count", tag, depth_of[k]), 64'(ocnt), 64'(mcnt[k]));
    end
  endtask

  task automatic set_inputs(logic v, logic [31:0] pc, logic [31:0] inst,
                            logic rdy, logic [2:0] kills);
    bus2.i_valid = v;  bus2.i_pc = pc;  bus2.i_inst = inst;  bus2.i_ready = rdy;
    bus2.flush = kills[0]; bus2.i_nt_pt = kills[1]; bus2.i_t_pnt = kills[2];
    bus4.i_valid = v;  bus4.i_pc = pc;  bus4.i_inst = inst;  bus4.i_ready = rdy;
    bus4.flush = kills[0]; bus4.i_nt_pt = kills[1]; bus4.i_t_pnt = kills[2];
  endtask

  // One clock cycle: check current outputs, apply inputs, advance the model.
  task automatic step(string tag, logic v, logic [31:0] pc, logic [31:0] inst,
                      logic rdy, logic [2:0] kills);
    logic kill, push, pop;
    @(negedge clk);
    check_outputs(tag);
    set_inputs(v, pc, inst, rdy, kills);
    kill = |kills;
    for (int k = 0; k < 2; k++) begin
      push = v && (mcnt[k] < depth_of[k]) && !kill;
      pop  = (mcnt[k] != 0) && rdy && !kill;
      if (kill) begin
        mcnt[k] = 0;
      end else begin
        if (pop) begin
          for (int j = 0; j < 7; j++) mdat[k][j] = mdat[k][j+1];
          mcnt[k]--;
        end
        if (push) begin
          mdat[k][mcnt[k]] = {pc, inst};
          mcnt[k]++;
        end
      end
    end
    $display("%s: v=%0b pc=%h rdy=%0b kill=%b -> cnt2=%0d cnt4=%0d",
             tag, v, pc, rdy, kills, mcnt[0], mcnt[1]);
    @(posedge clk);
  endtask

  initial begin
    rst = 1'b1;
    mcnt[0] = 0;
    mcnt[1] = 0;
    set_inputs(1'b0, 32'd0, 32'd0, 1'b0, 3'b000);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_outputs("in_reset");
    rst = 1'b0;

    // Single push held until decode is ready.
    step("single", 1'b1, 32'h100, 32'h13, 1'b0, 3'b000);
    step("hold", 1'b0, 32'h0, 32'h0, 1'b0, 3'b000);
    step("hold", 1'b0, 32'h0, 32'h0, 1'b0, 3'b000);
    step("pop", 1'b0, 32'h0, 32'h0, 1'b1, 3'b000);
    step("idle", 1'b0, 32'h0, 32'h0, 1'b0, 3'b000);

    // Fill past capacity, then drain in order.
    for (int i = 0; i < 3; i++)
      step("fill", 1'b1, 32'h100 + 32'(4*i), 32'hA000 + 32'(i), 1'b0, 3'b000);
    for (int i = 0; i < 4; i++)
      step("drain", 1'b0, 32'h0, 32'h0, 1'b1, 3'b000);

    // Streaming push+pop.
    for (int i = 0; i < 8; i++)
      step("stream", 1'b1, 32'h200 + 32'(4*i), 32'hB000 + 32'(i), 1'b1, 3'b000);
    for (int i = 0; i < 4; i++)
      step("stream_drain", 1'b0, 32'h0, 32'h0, 1'b1, 3'b000);

    // Each kill source empties the queue and drops the concurrent push.
    for (int b = 0; b < 3; b++) begin
      step("kfill", 1'b1, 32'h2F0, 32'hC000, 1'b0, 3'b000);
      step("kfill", 1'b1, 32'h2F4, 32'hC001, 1'b0, 3'b000);
      step("kill", 1'b1, 32'h300, 32'hC002, 1'b1, 3'(1 << b));
      step("after_kill", 1'b1, 32'h304, 32'hC003, 1'b0, 3'b000);
      step("kdrain", 1'b0, 32'h0, 32'h0, 1'b1, 3'b000);
      step("kdrain", 1'b0, 32'h0, 32'h0, 1'b1, 3'b000);
    end

    // Asynchronous reset while full, checked before any clock edge.
    for (int i = 0; i < 4; i++)
      step("afill", 1'b1, 32'h380 + 32'(4*i), 32'hD000 + 32'(i), 1'b0, 3'b000);
    #3;
    rst = 1'b1;
    set_inputs(1'b0, 32'd0, 32'd0, 1'b0, 3'b000);
    mcnt[0] = 0;
    mcnt[1] = 0;
    #1;
    check_outputs("async_rst");
    @(negedge clk);
    rst = 1'b0;
    step("post_rst", 1'b1, 32'h400, 32'hE000, 1'b0, 3'b000);
    step("post_rst", 1'b0, 32'h0, 32'h0, 1'b1, 3'b000);
    step("post_rst", 1'b0, 32'h0, 32'h0, 1'b0, 3'b000);

    // Full queue then simultaneous push/pop requests.
    for (int i = 0; i < 4; i++)
      step("ffill", 1'b1, 32'h500 + 32'(4*i), 32'hF000 + 32'(i), 1'b0, 3'b000);
    for (int i = 0; i < 6; i++)
      step("fpp", 1'b1, 32'h600 + 32'(4*i), 32'hF100 + 32'(i), 1'b1, 3'b000);
    for (int i = 0; i < 6; i++)
      step("fdrain", 1'b0, 32'h0, 32'h0, 1'b1, 3'b000);

    // Random traffic.
    for (int i = 0; i < 300; i++) begin
      logic [2:0] kills;
      kills[0] = ($urandom_range(0, 19) == 0);
      kills[1] = ($urandom_range(0, 29) == 0);
      kills[2] = ($urandom_range(0, 29) == 0);
      step("rand", 1'($urandom_range(0, 3) != 0), $urandom, $urandom,
           1'($urandom_range(0, 2) != 0), kills);
    end

    @(negedge clk);
    check_outputs("final");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
